// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction memory loader: FSM encoding and
// memory geometry.
package imem_loader_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int IMEM_DEPTH     = 64;
   localparam int LEN_W          = 7;

   localparam logic [LEN_W-1:0] MAX_LOAD_LEN = LEN_W'(IMEM_DEPTH);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RECV  = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_CHECK = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // The core must stall in every state that touches the stream or memory.
   function automatic logic is_busy_state(input logic [2:0] st);
      return (st == ST_RECV) || (st == ST_WRITE) || (st == ST_CHECK);
   endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into a word; strobes when the fourth
// byte of a word is accepted.
module imem_word_packer
   import imem_loader_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic              i_byte_en,
   input  logic [7:0]        i_byte,
   output logic [DATA_W-1:0] o_word,
   output logic              o_word_done
);

   logic [1:0]        r_lane;
   logic [DATA_W-1:0] r_word;

   // Right shift: after four bytes the first one has landed in bits [7:0].
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lane <= 2'd0;
         r_word <= '0;
      end else if (i_clear) begin
         r_lane <= 2'd0;
         r_word <= '0;
      end else if (i_byte_en) begin
         r_word <= {i_byte, r_word[DATA_W-1:8]};
         r_lane <= r_lane + 2'd1;
      end
   end

   assign o_word      = r_word;
   assign o_word_done = i_byte_en && (r_lane == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into the instruction memory write port, one 32-bit word per
// four bytes, then verifies a trailing XOR checksum byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int                ADDR_W    = 6,
   parameter int                DATA_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [6:0]        load_len,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [6:0]        words_written
);

   logic [2:0]        r_state;
   logic [2:0]        w_state_next;
   logic [6:0]        r_len;
   logic [7:0]        r_csum;
   logic [ADDR_W-1:0] r_addr;
   logic [6:0]        r_ww;
   logic              r_err;
   logic              r_in_ready;
   logic              r_busy;
   logic              r_we;
   logic              r_done;

   logic              w_accept;
   logic              w_byte_en;
   logic              w_clear;
   logic              w_word_done;
   logic [6:0]        w_ww_inc;
   logic [DATA_W-1:0] w_word;

   assign w_accept  = in_valid && r_in_ready;
   assign w_byte_en = w_accept && (r_state == ST_RECV);
   assign w_clear   = (r_state == ST_IDLE) && start;
   assign w_ww_inc  = r_ww + 7'd1;

   imem_word_packer #(
      .DATA_W (DATA_W)
   ) u_packer (
      .clk         (clk),
      .rst         (rst),
      .i_clear     (w_clear),
      .i_byte_en   (w_byte_en),
      .i_byte      (in_data),
      .o_word      (w_word),
      .o_word_done (w_word_done)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (load_len == 7'd0)               w_state_next = ST_CHECK;
               else if (load_len > MAX_LOAD_LEN)   w_state_next = ST_DONE;
               else                                w_state_next = ST_RECV;
            end
         end
         ST_RECV:  if (w_word_done) w_state_next = ST_WRITE;
         ST_WRITE: w_state_next = (w_ww_inc == r_len) ? ST_CHECK : ST_RECV;
         ST_CHECK: if (w_accept) w_state_next = ST_DONE;
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Handshake and status outputs are registered from the next state so they
   // line up with the state they describe and never depend on in_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_len      <= 7'd0;
         r_csum     <= 8'd0;
         r_addr     <= BASE_ADDR;
         r_ww       <= 7'd0;
         r_err      <= 1'b0;
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_we       <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_in_ready <= (w_state_next == ST_RECV) || (w_state_next == ST_CHECK);
         r_busy     <= is_busy_state(w_state_next);
         r_we       <= (w_state_next == ST_WRITE);
         r_done     <= (w_state_next == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_len  <= load_len;
                  r_ww   <= 7'd0;
                  r_csum <= 8'd0;
                  r_addr <= BASE_ADDR;
                  r_err  <= (load_len > MAX_LOAD_LEN);
               end
            end
            ST_RECV: begin
               if (w_byte_en) r_csum <= r_csum ^ in_data;
            end
            ST_WRITE: begin
               r_addr <= r_addr + ADDR_W'(1);
               r_ww   <= w_ww_inc;
            end
            ST_CHECK: begin
               if (w_accept && (in_data != r_csum)) r_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign in_ready      = r_in_ready;
   assign imem_we       = r_we;
   assign imem_addr     = r_addr;
   assign imem_wdata    = w_word;
   assign busy          = r_busy;
   assign done          = r_done;
   assign err           = r_err;
   assign words_written = r_ww;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: captures every memory write and checks
// loads, checksum handling, length limits, reset and ignored starts.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [6:0]  load_len;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        imem_we;
   logic [5:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [6:0]  words_written;

   int tests_run    = 0;
   int tests_failed = 0;
   int overlap_cnt  = 0;

   logic [5:0]  wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   imem_loader dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .load_len      (load_len),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .imem_we       (imem_we),
      .imem_addr     (imem_addr),
      .imem_wdata    (imem_wdata),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .words_written (words_written)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wdata);
         $display("[TB] write addr=%0d data=0x%08h", imem_addr, imem_wdata);
         if (in_ready) overlap_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      overlap_cnt = 0;
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic do_start(input logic [6:0] len);
      start    = 1'b1;
      load_len = len;
      @(posedge clk); #1;
      start    = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) begin @(posedge clk); #1; end
      in_data  = b;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("byte_accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output logic e, output logic [6:0] ww, output logic b);
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", done, 1'b1);
      e  = err;
      ww = words_written;
      b  = busy;
      $display("[TB] load done err=%0b words=%0d", e, ww);
      @(posedge clk); #1;
   endtask

   task automatic run_basic(input logic [7:0] last_byte, input int maxgap,
                            input logic exp_err, input string tag);
      logic [7:0] s[9];
      logic       e;
      logic       b;
      logic [6:0] ww;
      s = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'h70, 8'h00, 8'hA0};
      s[8] = last_byte;
      clear_log();
      do_start(7'd2);
      chk({tag, "_busy_mid"}, busy, 1'b1);
      for (int i = 0; i < 9; i++)
         send_byte(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      wait_done(e, ww, b);
      chk({tag, "_nwrites"}, wr_addr_q.size(), 32'd2);
      if (wr_addr_q.size() >= 2) begin
         chk({tag, "_addr0"}, wr_addr_q[0], 32'd0);
         chk({tag, "_data0"}, wr_data_q[0], 32'h00500113);
         chk({tag, "_addr1"}, wr_addr_q[1], 32'd1);
         chk({tag, "_data1"}, wr_data_q[1], 32'h00700193);
      end
      chk({tag, "_err"}, e, exp_err);
      chk({tag, "_words"}, ww, 32'd2);
      chk({tag, "_busy_at_done"}, b, 1'b0);
      chk({tag, "_ready_in_write"}, overlap_cnt, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       e;
      logic       b;
      logic [6:0] ww;

      rst = 1'b1; start = 1'b0; load_len = 7'd0; in_data = 8'd0; in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_we", imem_we, 1'b0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_words", words_written, 32'd0);
      @(posedge clk); #1;

      run_basic(8'hA0, 0, 1'b0, "basic");
      run_basic(8'hA1, 0, 1'b1, "badsum");

      // Zero-length load: only a 0x00 checksum byte; the start clears err.
      clear_log();
      do_start(7'd0);
      chk("len0_err_cleared", err, 1'b0);
      chk("len0_busy", busy, 1'b1);
      send_byte(8'h00, 0);
      wait_done(e, ww, b);
      chk("len0_err", e, 1'b0);
      chk("len0_words", ww, 32'd0);
      chk("len0_nwrites", wr_addr_q.size(), 32'd0);

      run_basic(8'hA0, 3, 1'b0, "gaps");

      // Over-length request aborts immediately.
      clear_log();
      do_start(7'd65);
      @(negedge clk);
      chk("len65_done", done, 1'b1);
      chk("len65_err", err, 1'b1);
      chk("len65_in_ready", in_ready, 1'b0);
      chk("len65_busy", busy, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("len65_done_pulse", done, 1'b0);
      chk("len65_nwrites", wr_addr_q.size(), 32'd0);
      @(posedge clk); #1;

      // Full memory: byte k = k mod 256, so the XOR of all bytes is 0x00.
      clear_log();
      do_start(7'd64);
      for (int k = 0; k < 256; k++) send_byte(8'(k), 0);
      send_byte(8'h00, 0);
      wait_done(e, ww, b);
      chk("len64_nwrites", wr_addr_q.size(), 32'd64);
      chk("len64_words", ww, 32'd64);
      chk("len64_err", e, 1'b0);
      if (wr_addr_q.size() == 64) begin
         for (int i = 0; i < 64; i++) begin
            chk($sformatf("len64_addr%0d", i), wr_addr_q[i], 32'(i));
            chk($sformatf("len64_data%0d", i), wr_data_q[i],
                {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
         end
      end

      // A start during RECV must not change the latched length of 1.
      clear_log();
      do_start(7'd1);
      send_byte(8'h11, 0);
      start = 1'b1; load_len = 7'd5;
      @(posedge clk); #1;
      start = 1'b0;
      send_byte(8'h22, 0);
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      send_byte(8'h44, 0);
      wait_done(e, ww, b);
      chk("ignstart_words", ww, 32'd1);
      chk("ignstart_err", e, 1'b0);
      chk("ignstart_nwrites", wr_addr_q.size(), 32'd1);
      if (wr_data_q.size() >= 1) chk("ignstart_data", wr_data_q[0], 32'h44332211);

      // Reset after two bytes of the first word discards the partial word.
      clear_log();
      do_start(7'd1);
      send_byte(8'hDE, 0);
      send_byte(8'hAD, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_in_ready", in_ready, 1'b0);
      chk("midrst_we", imem_we, 1'b0);
      chk("midrst_addr", imem_addr, 32'd0);
      chk("midrst_wdata", imem_wdata, 32'd0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_err", err, 1'b0);
      chk("midrst_words", words_written, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("midrst_nwrites", wr_addr_q.size(), 32'd0);
      run_basic(8'hA0, 0, 1'b0, "after_rst");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
